// File: rtl/uart_operand_loader.sv
// uart_operand_loader: UART receiver that assembles 12-byte frames into six Q8.8 butterfly operands
// Operands are double-buffered: bytes land in shadow registers and all six outputs swap on the 12th byte.
module uart_operand_loader #(
    parameter int CLOCK_PER_BIT = 434,
    parameter int WORD_SIZE     = 16,
    parameter int TIMEOUT_BITS  = 20
) (
    input  logic                 i_clk,
    input  logic                 w_rst,
    input  logic                 i_RX_bit,
    output logic [WORD_SIZE-1:0] o_in0_re,
    output logic [WORD_SIZE-1:0] o_in0_im,
    output logic [WORD_SIZE-1:0] o_in1_re,
    output logic [WORD_SIZE-1:0] o_in1_im,
    output logic [WORD_SIZE-1:0] o_twiddle_re,
    output logic [WORD_SIZE-1:0] o_twiddle_im,
    output logic                 o_load_done,
    output logic [7:0]           o_RX_byte,
    output logic                 o_RX_valid,
    output logic                 o_frame_error,
    output logic                 o_timeout,
    output logic [3:0]           o_byte_index
);
    localparam int CW = $clog2(CLOCK_PER_BIT + 1);
    localparam int TW = $clog2(TIMEOUT_BITS * CLOCK_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLOCK_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_BITS * CLOCK_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

    state_t               r_state, w_next;
    logic                 r_rx_meta, r_rx;
    logic [CW-1:0]        r_clk_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic [TW-1:0]        r_to_cnt;
    logic                 r_wait_high;
    logic [3:0]           r_byte_idx;
    logic [7:0]           r_byte;
    logic                 r_valid, r_ferr, r_tout, r_done;
    logic [WORD_SIZE-1:0] r_shadow [6];
    logic [WORD_SIZE-1:0] r_ops [6];
    logic                 w_start, w_mid, w_tick, w_stop_ok, w_stop_bad, w_timeout, w_last;

    always_ff @(posedge i_clk or posedge w_rst)
        if (w_rst) {r_rx_meta, r_rx} <= 2'b11;
        else {r_rx_meta, r_rx} <= {i_RX_bit, r_rx_meta};

    always_ff @(posedge i_clk or posedge w_rst)
        if (w_rst) r_state <= IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_start ? START : IDLE;
            START:   w_next = !w_mid ? START : (r_rx ? IDLE : DATA);
            DATA:    w_next = (w_tick && r_bit_idx == 3'd7) ? STOP : DATA;
            STOP:    w_next = w_tick ? CLEANUP : STOP;
            CLEANUP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // After a bad stop bit the line may be in a break; no start is accepted until it has been seen high.
    always_comb begin
        w_start    = r_state == IDLE && !r_rx && !r_wait_high;
        w_mid      = r_clk_cnt == HALF_LAST;
        w_tick     = r_clk_cnt == BIT_LAST;
        w_stop_ok  = r_state == STOP && w_tick && r_rx;
        w_stop_bad = r_state == STOP && w_tick && !r_rx;
        w_timeout  = r_state == IDLE && !w_start && r_byte_idx != 4'd0 && r_to_cnt == TO_LAST;
        w_last     = r_byte_idx == 4'd11;
    end

    always_ff @(posedge i_clk or posedge w_rst)
        if (w_rst) begin
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_to_cnt    <= '0;
            r_wait_high <= 1'b0;
        end else begin
            r_clk_cnt   <= (r_state == IDLE || r_state == CLEANUP || w_next != r_state || w_tick) ? '0 : r_clk_cnt + 1'b1;
            r_bit_idx   <= r_state == IDLE ? 3'd0 : (r_state == DATA && w_tick) ? r_bit_idx + 1'b1 : r_bit_idx;
            r_shift     <= (r_state == DATA && w_tick) ? {r_rx, r_shift[7:1]} : r_shift;
            r_to_cnt    <= (r_state != IDLE || w_start || r_byte_idx == 4'd0 || w_timeout) ? '0 : r_to_cnt + 1'b1;
            r_wait_high <= w_stop_bad ? 1'b1 : (r_rx ? 1'b0 : r_wait_high);
        end

    always_ff @(posedge i_clk or posedge w_rst)
        if (w_rst) begin
            r_byte_idx <= '0;
            r_byte     <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_tout     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_byte_idx <= (w_stop_bad || w_timeout || (w_stop_ok && w_last)) ? 4'd0 : w_stop_ok ? r_byte_idx + 1'b1 : r_byte_idx;
            r_byte     <= w_stop_ok ? r_shift : r_byte;
            r_valid    <= w_stop_ok;
            r_ferr     <= w_stop_bad;
            r_tout     <= w_timeout;
            r_done     <= w_stop_ok && w_last;
        end

    // Byte k is the low (even k) or high (odd k) half of word k/2.
    always_ff @(posedge i_clk or posedge w_rst)
        if (w_rst) begin
            for (int i = 0; i < 6; i++) r_shadow[i] <= '0;
        end else if (w_stop_ok) begin
            if (r_byte_idx[0]) r_shadow[r_byte_idx[3:1]][15:8] <= r_shift;
            else r_shadow[r_byte_idx[3:1]][7:0] <= r_shift;
        end

    always_ff @(posedge i_clk or posedge w_rst)
        if (w_rst) begin
            for (int i = 0; i < 6; i++) r_ops[i] <= '0;
        end else if (w_stop_ok && w_last) begin
            for (int i = 0; i < 5; i++) r_ops[i] <= r_shadow[i];
            r_ops[5] <= {r_shift, r_shadow[5][7:0]};
        end

    assign o_in0_re      = r_ops[0];
    assign o_in0_im      = r_ops[1];
    assign o_in1_re      = r_ops[2];
    assign o_in1_im      = r_ops[3];
    assign o_twiddle_re  = r_ops[4];
    assign o_twiddle_im  = r_ops[5];
    assign o_load_done   = r_done;
    assign o_RX_byte     = r_byte;
    assign o_RX_valid    = r_valid;
    assign o_frame_error = r_ferr;
    assign o_timeout     = r_tout;
    assign o_byte_index  = r_byte_idx;
endmodule

// File: tb/tb_uart_operand_loader.sv
// tb_uart_operand_loader: scoreboard bench for uart_operand_loader
// Expected bytes and operand sets are queued as they are sent and checked when the DUT reports them.
`timescale 1ns/1ps
module tb_uart_operand_loader;
    localparam int CPB    = 16;
    localparam int CPB_LB = 434;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, rx = 1'b1, rx_lb = 1'b1;
    logic [15:0] in0_re, in0_im, in1_re, in1_im, tw_re, tw_im;
    logic [7:0]  rx_byte;
    logic        rx_valid, ferr, tout, done;
    logic [3:0]  bidx;
    logic [95:0] dut_ops;
    logic [15:0] lb_w [6];
    logic [7:0]  lb_byte;
    logic        lb_valid, lb_ferr, lb_tout, lb_done;
    logic [3:0]  lb_idx;

    assign dut_ops = {in0_re, in0_im, in1_re, in1_im, tw_re, tw_im};

    uart_operand_loader #(.CLOCK_PER_BIT(CPB), .WORD_SIZE(16), .TIMEOUT_BITS(20)) dut (
        .i_clk(clk), .w_rst(rst), .i_RX_bit(rx),
        .o_in0_re(in0_re), .o_in0_im(in0_im), .o_in1_re(in1_re), .o_in1_im(in1_im),
        .o_twiddle_re(tw_re), .o_twiddle_im(tw_im), .o_load_done(done),
        .o_RX_byte(rx_byte), .o_RX_valid(rx_valid), .o_frame_error(ferr),
        .o_timeout(tout), .o_byte_index(bidx)
    );

    uart_operand_loader #(.CLOCK_PER_BIT(CPB_LB), .WORD_SIZE(16), .TIMEOUT_BITS(20)) dut_lb (
        .i_clk(clk), .w_rst(rst), .i_RX_bit(rx_lb),
        .o_in0_re(lb_w[0]), .o_in0_im(lb_w[1]), .o_in1_re(lb_w[2]), .o_in1_im(lb_w[3]),
        .o_twiddle_re(lb_w[4]), .o_twiddle_im(lb_w[5]), .o_load_done(lb_done),
        .o_RX_byte(lb_byte), .o_RX_valid(lb_valid), .o_frame_error(lb_ferr),
        .o_timeout(lb_tout), .o_byte_index(lb_idx)
    );

    logic [7:0]  q_byte [$];
    logic [95:0] q_ops [$];
    logic [95:0] cur_ops = '0;
    logic [7:0]  mon_b;
    logic [95:0] mon_o;
    int          exp_idx = 0;
    int          n_cmp = 0, n_err = 0;
    int          n_valid = 0, n_done = 0, n_ferr = 0, n_tout = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (!rst) begin
            if (rx_valid) begin
                n_valid++;
                n_cmp++;
                if (q_byte.size() == 0) begin
                    n_err++;
                    $display("FAIL rx_byte: unexpected valid with byte %h", rx_byte);
                end else begin
                    mon_b = q_byte.pop_front();
                    if (rx_byte !== mon_b) begin
                        n_err++;
                        $display("FAIL rx_byte: got %h expected %h", rx_byte, mon_b);
                    end
                end
            end
            if (done) begin
                n_done++;
                n_cmp++;
                if (q_ops.size() == 0) begin
                    n_err++;
                    $display("FAIL load_ops: unexpected load_done with %h", dut_ops);
                end else begin
                    mon_o = q_ops.pop_front();
                    if (dut_ops !== mon_o) begin
                        n_err++;
                        $display("FAIL load_ops: got %h expected %h", dut_ops, mon_o);
                    end
                end
            end
            n_ferr += int'(ferr);
            n_tout += int'(tout);
        end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        if (stop) q_byte.push_back(b);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        if (!stop) begin
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        exp_idx = !stop ? 0 : (exp_idx == 11) ? 0 : exp_idx + 1;
    endtask

    task automatic send_ops(input logic [95:0] ops);
        logic [15:0] w;
        q_ops.push_back(ops);
        for (int j = 0; j < 6; j++) begin
            w = ops[95-16*j -: 16];
            send_byte(w[7:0], 1'b1);
            send_byte(w[15:8], 1'b1);
        end
        cur_ops = ops;
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if (bidx !== 4'(exp_idx)) begin
            n_err++;
            $display("FAIL %s_index: got %0d expected %0d", name, bidx, exp_idx);
        end
        n_cmp++;
        if (dut_ops !== cur_ops) begin
            n_err++;
            $display("FAIL %s_ops: got %h expected %h", name, dut_ops, cur_ops);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({dut_ops, rx_byte, rx_valid, ferr, tout, done, bidx} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ops %h byte %h pulses %b%b%b%b idx %0d expected all 0",
                     dut_ops, rx_byte, rx_valid, ferr, tout, done, bidx);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_idle("reset");
    endtask

    task automatic test_spec_frame;
        logic [95:0] seq = {8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h03, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00};
        logic [95:0] want = {16'h0200, 16'h0100, 16'h0300, 16'hFF00, 16'h0100, 16'h0000};
        int v0 = n_valid, d0 = n_done;
        q_ops.push_back(want);
        for (int k = 0; k < 12; k++) begin
            send_byte(seq[95-8*k -: 8], 1'b1);
            if (k == 5) check_idle("spec_partial");
        end
        cur_ops = want;
        check_idle("spec_loaded");
        n_cmp++;
        if (n_valid - v0 !== 12 || n_done - d0 !== 1) begin
            n_err++;
            $display("FAIL spec_counts: got %0d valid %0d done expected 12 valid 1 done", n_valid - v0, n_done - d0);
        end
    endtask

    task automatic test_break;
        int f0 = n_ferr, v0 = n_valid;
        rx = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        exp_idx = 0;
        n_cmp++;
        if (n_ferr - f0 !== 1 || n_valid - v0 !== 0) begin
            n_err++;
            $display("FAIL break_pulses: got %0d ferr %0d valid expected 1 ferr 0 valid", n_ferr - f0, n_valid - v0);
        end
        send_byte(8'h5A, 1'b1);
        check_idle("break_recover");
    endtask

    task automatic test_frame_error;
        int f0, v0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check_idle("ferr_before");
        f0 = n_ferr;
        v0 = n_valid;
        send_byte(8'hA5, 1'b0);
        n_cmp++;
        if (n_ferr - f0 !== 1 || n_valid - v0 !== 0) begin
            n_err++;
            $display("FAIL ferr_pulses: got %0d ferr %0d valid expected 1 ferr 0 valid", n_ferr - f0, n_valid - v0);
        end
        check_idle("ferr_after");
    endtask

    task automatic test_timeout;
        int t0 = n_tout;
        for (int k = 0; k < 5; k++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        repeat (19 * CPB) @(negedge clk);
        n_cmp++;
        if (n_tout - t0 !== 0 || bidx !== 4'd5) begin
            n_err++;
            $display("FAIL timeout_early: got %0d timeouts idx %0d expected 0 timeouts idx 5", n_tout - t0, bidx);
        end
        repeat (2 * CPB) @(negedge clk);
        exp_idx = 0;
        n_cmp++;
        if (n_tout - t0 !== 1) begin
            n_err++;
            $display("FAIL timeout_pulse: got %0d expected 1", n_tout - t0);
        end
        check_idle("timeout");
        repeat (25 * CPB) @(negedge clk);
        n_cmp++;
        if (n_tout - t0 !== 1) begin
            n_err++;
            $display("FAIL timeout_once: got %0d expected 1", n_tout - t0);
        end
        send_ops({$urandom, $urandom, $urandom});
        check_idle("timeout_reload");
    endtask

    task automatic test_glitch;
        int v0 = n_valid, f0 = n_ferr, t0 = n_tout, d0 = n_done;
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n_cmp++;
        if (n_valid - v0 + n_ferr - f0 + n_tout - t0 + n_done - d0 !== 0) begin
            n_err++;
            $display("FAIL glitch_pulses: got %0d valid %0d ferr %0d tout %0d done expected none",
                     n_valid - v0, n_ferr - f0, n_tout - t0, n_done - d0);
        end
        check_idle("glitch");
        send_ops({$urandom, $urandom, $urandom});
        check_idle("glitch_reload");
    endtask

    task automatic test_reset_mid;
        logic [7:0] b = 8'hB7;
        for (int k = 0; k < 7; k++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b[4];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({dut_ops, rx_byte, rx_valid, ferr, tout, done, bidx} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got ops %h byte %h idx %0d expected all 0", dut_ops, rx_byte, bidx);
        end
        rx = 1'b1;
        cur_ops = '0;
        exp_idx = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send_ops({$urandom, $urandom, $urandom});
        check_idle("reset_reload");
    endtask

    task automatic test_back_to_back;
        int d0 = n_done;
        send_ops({$urandom, $urandom, $urandom});
        send_ops({$urandom, $urandom, $urandom});
        n_cmp++;
        if (n_done - d0 !== 2) begin
            n_err++;
            $display("FAIL b2b_done: got %0d expected 2", n_done - d0);
        end
        check_idle("b2b");
    endtask

    task automatic test_loopback;
        logic [7:0] b = 8'hC3;
        int c0;
        int lat = -1;
        logic fe = 1'b0;
        @(negedge clk);
        c0 = cyc;
        fork
            begin
                rx_lb = 1'b0;
                repeat (CPB_LB) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    rx_lb = b[i];
                    repeat (CPB_LB) @(negedge clk);
                end
                rx_lb = 1'b1;
                repeat (CPB_LB) @(negedge clk);
            end
            begin
                for (int i = 0; i < 11 * CPB_LB && lat < 0; i++) begin
                    @(negedge clk);
                    fe = fe | lb_ferr;
                    if (lb_valid) lat = cyc - c0;
                end
            end
        join
        n_cmp++;
        if (lat < CPB_LB * 19 / 2 || lat > CPB_LB * 19 / 2 + 5) begin
            n_err++;
            $display("FAIL loopback_latency: got %0d cycles expected %0d..%0d", lat, CPB_LB * 19 / 2, CPB_LB * 19 / 2 + 5);
        end
        n_cmp++;
        if (lb_byte !== b || fe !== 1'b0) begin
            n_err++;
            $display("FAIL loopback_byte: got %h ferr %b expected %h ferr 0", lb_byte, fe, b);
        end
    endtask

    initial begin
        test_reset();
        test_spec_frame();
        test_break();
        test_frame_error();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        test_loopback();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (q_byte.size() !== 0 || q_ops.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d bytes %0d op sets left expected 0", q_byte.size(), q_ops.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
